uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a configurable frame format (data bits, parity, stop bits), mid-bit sampling, per-frame error reporting and an integrated first-word-fall-through receive FIFO with a ready/valid output. It is the next-generation serial input path of the CPU's memory-mapped UART. It decouples byte arrival from software polling, so a BIOS echo loop can fall several characters behind without losing input.

---
 rtl/uart_rx_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, per-frame error pulses and a
// first-word-fall-through receive FIFO presented as a ready/valid stream.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int P     = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF  = P / 2;
    localparam int CNT_W = $clog2(P);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (P < 4) begin : g_bad_baud
        $error("CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {
        S_ARM, S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (PARITY == 1) ? ~x : x;
    endfunction

    logic rx_p0, rx_p1, rx;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0] bit_idx, bit_nx;
    logic stop_idx, stop_nx;
    logic par_bad, par_bad_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic push_p1, push_nx, ferr_nx, perr_nx;
    logic tick;

    // Stage 0/1: two-flop synchronizer for the asynchronous line
    always_ff @(posedge clk) begin
        rx_p0 <= serial_in;
        rx_p1 <= rx_p0;
    end
    assign rx   = rx_p1;
    assign tick = (cnt == CNT_LAST);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        bit_nx     = bit_idx;
        stop_nx    = stop_idx;
        par_bad_nx = par_bad;
        shreg_nx   = shreg;
        push_nx    = 1'b0;
        ferr_nx    = 1'b0;
        perr_nx    = 1'b0;
        case (state)
            S_ARM: begin
                cnt_nx = '0;
                if (rx) state_nx = S_IDLE;
            end
            S_IDLE: begin
                cnt_nx = '0;
                if (!rx) begin
                    state_nx   = S_START;
                    bit_nx     = '0;
                    stop_nx    = 1'b0;
                    par_bad_nx = 1'b0;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx   = '0;
                    state_nx = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_nx   = '0;
                    shreg_nx = {rx, shreg[DATA_BITS-1:1]};
                    bit_nx   = bit_idx + 4'd1;
                    if (bit_idx == BIT_LAST) state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (tick) begin
                    cnt_nx     = '0;
                    par_bad_nx = parity_bad(shreg, rx);
                    state_nx   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_nx  = '0;
                    stop_nx = 1'b1;
                    if (!rx) begin
                        // A low stop bit outranks any parity result
                        ferr_nx  = 1'b1;
                        state_nx = S_BREAK;
                    end else if (stop_idx == STOP_LAST) begin
                        perr_nx  = par_bad;
                        push_nx  = ~par_bad;
                        state_nx = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                cnt_nx = '0;
                if (rx) state_nx = S_IDLE;
            end
            default: state_nx = S_ARM;
        endcase
    end

    // Stage 2: registered frame decision
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_ARM;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            par_bad      <= 1'b0;
            push_p1      <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bit_idx      <= bit_nx;
            stop_idx     <= stop_nx;
            par_bad      <= par_bad_nx;
            push_p1      <= push_nx;
            frame_error  <= ferr_nx;
            parity_error <= perr_nx;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nx;
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic full, pop, wr;

    assign full    = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop     = data_out_valid && data_out_ready;
    assign wr      = push_p1 && (!full || pop);
    assign overrun = push_p1 && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= shreg;
    end

    assign data_out       = mem[rptr];
    assign data_out_valid = (count != '0);
    assign fifo_count     = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and a 7E1 instance driven
// with directed and random frames, checked by a negedge monitor.
module tb_uart_rx_fifo;
    localparam int CF = 50_000_000;
    localparam int BR = 1_000_000;
    localparam int P  = CF / BR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line0 = 1'b1, line1 = 1'b1;
    logic ready0 = 1'b0, ready1 = 1'b0;
    logic [7:0] dout0;
    logic [6:0] dout1;
    logic v0, fe0, pe0, ov0, v1, fe1, pe1, ov1;
    logic [3:0] cnt0, cnt1;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .rst(rst), .serial_in(line0), .data_out(dout0),
        .data_out_valid(v0), .data_out_ready(ready0), .frame_error(fe0),
        .parity_error(pe0), .overrun(ov0), .fifo_count(cnt0));

    uart_rx_fifo #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .rst(rst), .serial_in(line1), .data_out(dout1),
        .data_out_valid(v1), .data_out_ready(ready1), .frame_error(fe1),
        .parity_error(pe1), .overrun(ov1), .fifo_count(cnt1));

    int n_checks = 0, n_fail = 0;
    logic [8:0] exp0[$], exp1[$];
    int fe_seen0 = 0, pe_seen0 = 0, ov_seen0 = 0, vcyc0 = 0;
    int fe_seen1 = 0, pe_seen1 = 0, ov_seen1 = 0;
    int fe_exp0 = 0, pe_exp0 = 0, ov_exp0 = 0;
    int fe_exp1 = 0, pe_exp1 = 0, ov_exp1 = 0;
    bit done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (fe0) fe_seen0++;
            if (pe0) pe_seen0++;
            if (ov0) ov_seen0++;
            if (fe1) fe_seen1++;
            if (pe1) pe_seen1++;
            if (ov1) ov_seen1++;
            if (v0) vcyc0++;
            if (v0 && ready0) begin
                if (exp0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut0_unexpected_word: got %0d expected none", dout0);
                end else begin
                    e = exp0.pop_front();
                    check("dut0_data", int'(dout0), int'(e));
                end
            end
            if (v1 && ready1) begin
                if (exp1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut1_unexpected_word: got %0d expected none", dout1);
                end else begin
                    e = exp1.pop_front();
                    check("dut1_data", int'(dout1), int'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic b, input int cycles);
        if (which == 0) line0 = b; else line1 = b;
        repeat (cycles) tick();
    endtask

    task automatic idle(input int which, input int cycles);
        drive(which, 1'b1, cycles);
    endtask

    // Reference model: frame outcome from the frame-format rules, FIFO as a queue
    task automatic model(input int which, input logic [8:0] d, input logic par, input logic stop);
        bit par_ok;
        par_ok = (which == 0) || ((($countones(d[6:0]) + int'(par)) % 2) == 0);
        if (which == 0) begin
            if (!stop) fe_exp0++;
            else if (exp0.size() >= 8) ov_exp0++;
            else exp0.push_back(d);
        end else begin
            if (!stop) fe_exp1++;
            else if (!par_ok) pe_exp1++;
            else if (exp1.size() >= 8) ov_exp1++;
            else exp1.push_back(d);
        end
    endtask

    task automatic send(input int which, input logic [8:0] d, input logic par,
                        input logic stop, input bit use_model);
        int nb;
        nb = (which == 0) ? 8 : 7;
        if (use_model) model(which, d, par, stop);
        drive(which, 1'b0, P);
        for (int i = 0; i < nb; i++) drive(which, d[i], P);
        if (which == 1) drive(which, par, P);
        drive(which, stop, P);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, base_flags;
        logic [31:0] r;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("reset_valid0", int'(v0), 0);
        check("reset_count0", int'(cnt0), 0);
        check("reset_flags0", int'({fe0, pe0, ov0}), 0);
        check("reset_valid1", int'(v1), 0);
        check("reset_count1", int'(cnt1), 0);
        check("reset_flags1", int'({fe1, pe1, ov1}), 0);

        ready0 = 1'b1;
        base = vcyc0;
        send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        idle(0, 2 * P);
        check("basic_valid_cycles", vcyc0 - base, 1);
        check("basic_count", int'(cnt0), 0);
        check("basic_no_errors", fe_seen0 + pe_seen0 + ov_seen0, 0);

        ready0 = 1'b0;
        for (int i = 0; i < 9; i++) send(0, 9'(i), 1'b0, 1'b1, 1'b1);
        idle(0, P);
        check("fill_count", int'(cnt0), 8);
        check("fill_overrun", ov_seen0, ov_exp0);
        check("fill_overrun_once", ov_seen0, 1);
        ready0 = 1'b1;
        base = vcyc0;
        repeat (12) tick();
        check("drain_valid_cycles", vcyc0 - base, 8);
        check("drain_count", int'(cnt0), 0);
        check("drain_queue_empty", exp0.size(), 0);

        send(0, 9'h055, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 3 * P);
        idle(0, P);
        send(0, 9'h03C, 1'b0, 1'b1, 1'b1);
        idle(0, 2 * P);
        check("frame_error_count", fe_seen0, 1);
        check("frame_queue_empty", exp0.size(), 0);

        base = vcyc0;
        base_flags = fe_seen0 + pe_seen0 + ov_seen0;
        drive(0, 1'b0, 10);
        idle(0, 3 * P);
        check("false_start_valid", vcyc0 - base, 0);
        check("false_start_flags", fe_seen0 + pe_seen0 + ov_seen0 - base_flags, 0);

        send(1, 9'h041, 1'b0, 1'b1, 1'b1);
        idle(1, P);
        check("parity_good_count", int'(cnt1), 1);
        send(1, 9'h041, 1'b1, 1'b1, 1'b1);
        idle(1, P);
        check("parity_bad_count", int'(cnt1), 1);
        check("parity_error_pulse", pe_seen1, 1);
        ready1 = 1'b1;
        repeat (4) tick();
        check("parity_drained", int'(cnt1), 0);

        ready0 = 1'b0;
        send(0, 9'h077, 1'b0, 1'b1, 1'b1);
        idle(0, P);
        check("pre_reset_count", int'(cnt0), 1);
        base_flags = fe_seen0 + pe_seen0 + ov_seen0;
        fork
            send(0, 9'h0F0, 1'b0, 1'b1, 1'b0);
            begin
                // lands in data bit 3, which is low
                repeat (4 * P + P / 2) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                exp0.delete();
            end
        join
        idle(0, 6 * P);
        check("reset_flush_count", int'(cnt0), 0);
        check("reset_flush_valid", int'(v0), 0);
        check("reset_no_flags", fe_seen0 + pe_seen0 + ov_seen0 - base_flags, 0);
        ready0 = 1'b1;
        send(0, 9'h012, 1'b0, 1'b1, 1'b1);
        idle(0, 2 * P);
        check("post_reset_queue_empty", exp0.size(), 0);

        fork
            begin
                fork
                    for (int i = 0; i < 20; i++) begin
                        r = $urandom;
                        send(0, {1'b0, r[7:0]}, 1'b0, 1'b1, 1'b1);
                        idle(0, int'(r[9:8] % 3) * P);
                    end
                    for (int i = 0; i < 20; i++) begin
                        r = $urandom;
                        send(1, {2'b0, r[6:0]}, (^r[6:0]) ^ (r[9:8] == 2'd0),
                             (r[9:8] != 2'd1), 1'b1);
                        idle(1, P + int'(r[11:10] % 3) * P);
                    end
                join
                done = 1'b1;
            end
            while (!done) begin
                tick();
                ready0 = 1'($urandom_range(0, 1));
                ready1 = 1'($urandom_range(0, 1));
            end
        join
        ready0 = 1'b1;
        ready1 = 1'b1;
        for (int i = 0; i < 100 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
        check("final_queue0_empty", exp0.size(), 0);
        check("final_queue1_empty", exp1.size(), 0);
        check("final_fe0", fe_seen0, fe_exp0);
        check("final_pe0", pe_seen0, pe_exp0);
        check("final_ov0", ov_seen0, ov_exp0);
        check("final_fe1", fe_seen1, fe_exp1);
        check("final_pe1", pe_seen1, pe_exp1);
        check("final_ov1", ov_seen1, ov_exp1);
        check("final_count0", int'(cnt0), 0);
        check("final_count1", int'(cnt1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
